// File: rtl/ssd_decoder.sv
// ssd_decoder: recovers the two digits shown on a two-digit multiplexed 7-segment bus.
// Define SSD_DECODER_ERR_CNT_EN to build the saturating err_count; otherwise it reads 0.

module ssd_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic       chip_sel,
  output logic [3:0] digit_lo,
  output logic [3:0] digit_hi,
  output logic       lo_ok,
  output logic       hi_ok,
  output logic       lo_blank,
  output logic       hi_blank,
  output logic       frame_valid,
  output logic       stale,
  output logic [7:0] err_count
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_HIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_HIT    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    WAIT_BOTH = 1'b0,
    EMIT      = 1'b1
  } state_t;

  // 2-flop synchronizers plus one more stage holding the previous synchronized value
  logic [6:0] seg_m, seg_s, seg_p;
  logic       cs_m, cs_s, cs_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m <= '0;
      seg_s <= '0;
      seg_p <= '0;
      cs_m  <= 1'b0;
      cs_s  <= 1'b0;
      cs_p  <= 1'b0;
    end else begin
      seg_m <= seg;
      seg_s <= seg_m;
      seg_p <= seg_s;
      cs_m  <= chip_sel;
      cs_s  <= cs_m;
      cs_p  <= cs_s;
    end
  end

  logic stable, cs_edge, capture;
  logic [1:0] cap_slot;

  assign stable  = (seg_s == seg_p) && (cs_s == cs_p);
  assign cs_edge = cs_s ^ cs_p;

  logic [SW-1:0] stab_cnt;

  // Saturating at SETTLE_MAX leaves the counter parked so a stable period fires once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       stab_cnt <= '0;
    else if (!stable)                 stab_cnt <= '0;
    else if (stab_cnt != SETTLE_MAX)  stab_cnt <= stab_cnt + 1'b1;
  end

  assign capture  = stable && (stab_cnt == SETTLE_HIT);
  assign cap_slot = {capture & cs_s, capture & ~cs_s};

  logic [3:0] dec_val;
  logic       dec_ok, dec_blank;

  always_comb begin
    dec_val = 4'h0;
    dec_ok  = 1'b1;
    case (seg_s)
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  assign dec_blank = (seg_s == 7'h00);

  // Slot 0 = low digit, slot 1 = high digit
  logic [1:0][3:0] digit_q;
  logic [1:0]      ok_q, blank_q, upd_q;
  logic            clr_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
      ok_q    <= '0;
      blank_q <= '0;
      upd_q   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cap_slot[i]) begin
          if (dec_ok) digit_q[i] <= dec_val;
          ok_q[i]    <= dec_ok;
          blank_q[i] <= dec_blank;
        end
      end
      // A capture landing in the clear cycle survives the clear
      upd_q <= (upd_q & {2{~clr_upd}}) | cap_slot;
    end
  end

  state_t state_q, state_d;
  logic   emit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_BOTH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    clr_upd = 1'b0;
    case (state_q)
      WAIT_BOTH: if (&upd_q) state_d = EMIT;
      EMIT: begin
        emit    = 1'b1;
        clr_upd = 1'b1;
        state_d = WAIT_BOTH;
      end
      default: state_d = WAIT_BOTH;
    endcase
  end

  // stale comes out of reset high and stays sticky until the first cs edge
  logic [TW-1:0] tmo_q;
  logic          stale_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q   <= '0;
      stale_q <= 1'b1;
    end else if (cs_edge) begin
      tmo_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      if (tmo_q != TMO_MAX) tmo_q <= tmo_q + 1'b1;
      if (tmo_q >= TMO_HIT) stale_q <= 1'b1;
    end
  end

`ifdef SSD_DECODER_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 8'h00;
    else if (capture && !dec_ok && !dec_blank && (err_q != 8'hFF))
      err_q <= err_q + 8'h01;
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

  assign digit_lo    = digit_q[0];
  assign digit_hi    = digit_q[1];
  assign lo_ok       = ok_q[0];
  assign hi_ok       = ok_q[1];
  assign lo_blank    = blank_q[0];
  assign hi_blank    = blank_q[1];
  assign frame_valid = emit;
  assign stale       = stale_q;

endmodule
